// File: rtl/flash_arb_pkg.sv
// Shared state encoding, op codes and field widths for the flash request arbiter.
package flash_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_START,
      ST_WAIT_END,
      ST_DONE
   } arb_state_t;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   localparam int ADDR_W = 24;
   localparam int NBR_W  = 8;
   localparam int NBW_W  = 32;

endpackage

// File: rtl/flash_req_arbiter_cs_quiet_detector.sv
// Watches CSbar: remembers the first fall since clear and flags the cycle that completes
// QUIET_CYC consecutive high samples after a fall (quiet is combinational on that last sample).
module cs_quiet_detector #(
   parameter int unsigned QUIET_CYC = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic CSbar,
   input  logic clear,
   output logic seen_low,
   output logic quiet
);

   localparam int unsigned QW = (QUIET_CYC > 2) ? $clog2(QUIET_CYC) : 1;
   localparam logic [QW-1:0] Q_LAST = QW'(QUIET_CYC - 1);

   logic [QW-1:0] quiet_cnt;
   logic          low_flag;

   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         quiet_cnt <= '0;
         low_flag  <= 1'b0;
      end else if (!CSbar) begin
         quiet_cnt <= '0;
         low_flag  <= 1'b1;
      end else if (quiet_cnt != Q_LAST) begin
         quiet_cnt <= quiet_cnt + 1'b1;
      end
   end

   // A fall on the current sample counts immediately so WAIT_START reacts without a bubble.
   assign seen_low = low_flag | ~CSbar;
   assign quiet    = low_flag & CSbar & (quiet_cnt == Q_LAST);

endmodule

// File: rtl/flash_req_arbiter.sv
// Round-robin share of the SPI flash path between R0/R1: ack one cycle after req, held reqs wait while busy,
// completion taken from CSbar quiet time. Macro FLASH_ARB_TIMEOUT_EN adds a busy watchdog (TIMEOUT cycles).
module flash_req_arbiter
   import flash_arb_pkg::*;
#(
   parameter int unsigned PULSE_LEN  = 4,
   parameter int unsigned START_WAIT = 256,
   parameter int unsigned QUIET_CYC  = 64,
   parameter int unsigned TIMEOUT    = 1048576
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_req,
   input  logic              r0_op,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [NBR_W-1:0]  r0_nbr,
   input  logic [NBW_W-1:0]  r0_nbw,
   output logic              r0_ack,
   output logic              r0_done,
   output logic              r0_err,
   input  logic              r1_req,
   input  logic              r1_op,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [NBR_W-1:0]  r1_nbr,
   input  logic [NBW_W-1:0]  r1_nbw,
   output logic              r1_ack,
   output logic              r1_done,
   output logic              r1_err,
   output logic              flash_read,
   output logic              flash_write,
   output logic [ADDR_W-1:0] flash_addr,
   output logic [NBR_W-1:0]  flash_nbr,
   output logic [NBW_W-1:0]  flash_nbw,
   input  logic              CSbar,
   output logic              direct_fifo,
   output logic              busy,
   output logic              owner
);

   localparam int unsigned SW = $clog2(START_WAIT);
   localparam logic [SW-1:0] PULSE_LAST = SW'(PULSE_LEN - 1);
   localparam logic [SW-1:0] START_LAST = SW'(START_WAIT - 1);

   arb_state_t    state, next_state;
   logic [SW-1:0] start_cnt;
   logic          seen_low, quiet, timeout;
   logic          grant, grant_idx, fin, fin_err, sel_op;

   cs_quiet_detector #(.QUIET_CYC(QUIET_CYC)) u_quiet (
      .clk      (clk),
      .rst      (rst),
      .CSbar    (CSbar),
      .clear    ((state == ST_IDLE) || (state == ST_DONE)),
      .seen_low (seen_low),
      .quiet    (quiet)
   );

`ifdef FLASH_ARB_TIMEOUT_EN
   localparam int unsigned WW = $clog2(TIMEOUT);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
   logic [WW-1:0] wd_cnt;

   always_ff @(posedge clk) begin
      if (!rst || state == ST_IDLE || state == ST_DONE) begin
         wd_cnt <= '0;
      end else if (wd_cnt != WD_LAST) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign timeout = (wd_cnt == WD_LAST);
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      grant      = 1'b0;
      grant_idx  = 1'b0;
      fin        = 1'b0;
      fin_err    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (r0_req || r1_req) begin
               grant      = 1'b1;
               // On a tie the requester that did not hold the last grant wins.
               grant_idx  = (r0_req && r1_req) ? ~owner : r1_req;
               next_state = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (timeout) begin
               fin     = 1'b1;
               fin_err = 1'b1;
            end else if (start_cnt == PULSE_LAST) begin
               next_state = ST_WAIT_START;
            end
         end
         ST_WAIT_START: begin
            if (timeout || (!seen_low && start_cnt == START_LAST)) begin
               fin     = 1'b1;
               fin_err = 1'b1;
            end else if (seen_low) begin
               next_state = ST_WAIT_END;
            end
         end
         ST_WAIT_END: begin
            if (timeout) begin
               fin     = 1'b1;
               fin_err = 1'b1;
            end else if (quiet) begin
               fin = 1'b1;
            end
         end
         ST_DONE:  next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
      if (fin) next_state = ST_DONE;
   end

   assign sel_op = grant_idx ? r1_op : r0_op;

   always_ff @(posedge clk) begin
      if (!rst) begin
         owner       <= 1'b1;
         r0_ack      <= 1'b0;
         r1_ack      <= 1'b0;
         r0_done     <= 1'b0;
         r1_done     <= 1'b0;
         r0_err      <= 1'b0;
         r1_err      <= 1'b0;
         flash_read  <= 1'b0;
         flash_write <= 1'b0;
         flash_addr  <= '0;
         flash_nbr   <= '0;
         flash_nbw   <= '0;
         start_cnt   <= '0;
      end else begin
         r0_ack  <= grant & ~grant_idx;
         r1_ack  <= grant &  grant_idx;
         r0_done <= fin & ~owner;
         r1_done <= fin &  owner;
         r0_err  <= fin & fin_err & ~owner;
         r1_err  <= fin & fin_err &  owner;
         if (grant) begin
            owner       <= grant_idx;
            flash_addr  <= grant_idx ? r1_addr : r0_addr;
            flash_nbr   <= grant_idx ? r1_nbr  : r0_nbr;
            flash_nbw   <= grant_idx ? r1_nbw  : r0_nbw;
            flash_read  <= (sel_op == OP_READ);
            flash_write <= (sel_op == OP_WRITE);
            start_cnt   <= '0;
         end else begin
            // Strobes fall on any exit from ISSUE, including a watchdog abort.
            if (state == ST_ISSUE && next_state != ST_ISSUE) begin
               flash_read  <= 1'b0;
               flash_write <= 1'b0;
            end
            if (start_cnt != START_LAST) start_cnt <= start_cnt + 1'b1;
         end
      end
   end

   assign busy        = (state != ST_IDLE);
   assign direct_fifo = (state == ST_IDLE) || (state == ST_DONE);

endmodule

// File: tb/tb_flash_req_arbiter.sv
// Randomized bench for flash_req_arbiter with a cycle-offset reference model of grant, strobe and completion rules.
module tb_flash_req_arbiter;
   import flash_arb_pkg::*;

   localparam int PULSE_LEN  = 4;
   localparam int START_WAIT = 256;
   localparam int QUIET_CYC  = 64;
   localparam int TIMEOUT    = 1000;
   localparam int MAXK       = 1300;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        r0_req = 1'b0, r0_op = 1'b0;
   logic [23:0] r0_addr = '0;
   logic [7:0]  r0_nbr = '0;
   logic [31:0] r0_nbw = '0;
   logic        r1_req = 1'b0, r1_op = 1'b0;
   logic [23:0] r1_addr = '0;
   logic [7:0]  r1_nbr = '0;
   logic [31:0] r1_nbw = '0;
   logic        r0_ack, r0_done, r0_err, r1_ack, r1_done, r1_err;
   logic        flash_read, flash_write;
   logic [23:0] flash_addr;
   logic [7:0]  flash_nbr;
   logic [31:0] flash_nbw;
   logic        CSbar = 1'b1;
   logic        direct_fifo, busy, owner;

   int          n_chk = 0;
   int          n_bad = 0;
   bit          prof [0:MAXK];
   bit          last_own = 1'b1;
   logic        e_op   [2];
   logic [23:0] e_addr [2];
   logic [7:0]  e_nbr  [2];
   logic [31:0] e_nbw  [2];

   flash_req_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .r0_req(r0_req), .r0_op(r0_op), .r0_addr(r0_addr), .r0_nbr(r0_nbr), .r0_nbw(r0_nbw),
      .r0_ack(r0_ack), .r0_done(r0_done), .r0_err(r0_err),
      .r1_req(r1_req), .r1_op(r1_op), .r1_addr(r1_addr), .r1_nbr(r1_nbr), .r1_nbw(r1_nbw),
      .r1_ack(r1_ack), .r1_done(r1_done), .r1_err(r1_err),
      .flash_read(flash_read), .flash_write(flash_write), .flash_addr(flash_addr),
      .flash_nbr(flash_nbr), .flash_nbw(flash_nbw), .CSbar(CSbar),
      .direct_fifo(direct_fifo), .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic load(input bit idx, input logic op, input logic [23:0] a,
                       input logic [7:0] nr, input logic [31:0] nw);
      e_op[idx] = op; e_addr[idx] = a; e_nbr[idx] = nr; e_nbw[idx] = nw;
      if (idx) begin r1_op = op; r1_addr = a; r1_nbr = nr; r1_nbw = nw; r1_req = 1'b1; end
      else     begin r0_op = op; r0_addr = a; r0_nbr = nr; r0_nbw = nw; r0_req = 1'b1; end
   endtask

   task automatic load_rand(input bit idx);
      load(idx, 1'($urandom_range(0, 1)), 24'($urandom), 8'($urandom), 32'($urandom));
   endtask

   task automatic prof_fill(input bit v);
      for (int k = 0; k <= MAXK; k++) prof[k] = v;
   endtask

   task automatic prof_low(input int from, input int len);
      for (int k = from; k < from + len && k <= MAXK; k++) prof[k] = 1'b0;
   endtask

   task automatic prof_rand(input int kind);
      int pos, len;
      prof_fill(1'b1);
      case (kind)
         0: begin
            pos = int'($urandom_range(5, 40));
            for (int f = 0; f < 3; f++) begin
               len = int'($urandom_range(1, 120));
               prof_low(pos, len);
               pos += len + int'($urandom_range(40, 64));
            end
         end
         1:       prof_fill(1'b1);
         default: prof_low(int'($urandom_range(250, 262)), 8);
      endcase
   endtask

   // Offsets count clock edges after the ack edge; CSbar value prof[k] is what edge k samples.
   task automatic model(output int off, output bit err);
      int run;
      bit seen;
      off = 0; err = 1'b0; run = 0; seen = 1'b0;
      for (int k = 1; k <= MAXK; k++) begin
`ifdef FLASH_ARB_TIMEOUT_EN
         if (k == TIMEOUT) begin off = k; err = 1'b1; return; end
`endif
         if (!seen) begin
            if (!prof[k]) seen = 1'b1;
            else if (k == START_WAIT) begin off = k; err = 1'b1; return; end
         end else if (prof[k]) begin
            run++;
            if (run == QUIET_CYC) begin off = k; return; end
         end else begin
            run = 0;
         end
      end
   endtask

   task automatic run_op(input bit idx, input int lat_exp);
      int lat, off_exp, off_got, strobe_n;
      bit err_exp, err_got;
      model(off_exp, err_exp);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(r0_ack || r1_ack) && lat < 600);
      chk("ack_lat", 64'(lat), 64'(lat_exp));
      chk("ack_id", 64'({r1_ack, r0_ack}), 64'(idx ? 2 : 1));
      chk("owner", 64'(owner), 64'(idx));
      chk("fld_addr", 64'(flash_addr), 64'(e_addr[idx]));
      chk("fld_nbr", 64'(flash_nbr), 64'(e_nbr[idx]));
      chk("fld_nbw", 64'(flash_nbw), 64'(e_nbw[idx]));
      chk("strobe_kind", 64'({flash_write, flash_read}), 64'(e_op[idx] ? 2 : 1));
      last_own = idx;
      if (idx) begin r1_req = 1'b0; r1_addr = 24'($urandom); r1_nbw = 32'($urandom); end
      else     begin r0_req = 1'b0; r0_addr = 24'($urandom); r0_nbw = 32'($urandom); end
      strobe_n = 1;
      off_got  = 0;
      err_got  = 1'b0;
      for (int k = 1; k <= MAXK; k++) begin
         CSbar = prof[k];
         @(negedge clk);
         if (flash_read || flash_write) strobe_n++;
         if (k == 2) chk("dfifo_busy", 64'({direct_fifo, busy}), 64'(1));
         if (r0_done || r1_done) begin
            off_got = k;
            err_got = r0_err | r1_err;
            chk("done_id", 64'({r1_done, r0_done}), 64'(idx ? 2 : 1));
            chk("dfifo_done", 64'(direct_fifo), 64'(1));
            chk("addr_hold", 64'(flash_addr), 64'(e_addr[idx]));
            break;
         end
      end
      chk("done_off", 64'(off_got), 64'(off_exp));
      if (off_got != 0) begin
         chk("done_err", 64'(err_got), 64'(err_exp));
         CSbar = 1'b1;
      end
      chk("strobe_len", 64'(strobe_n), 64'(PULSE_LEN));
   endtask

   task automatic do_tie();
      bit w;
      w = ~last_own;
      @(negedge clk);
      load_rand(1'b0);
      load_rand(1'b1);
      prof_rand(int'($urandom_range(0, 2)));
      run_op(w, 1);
      prof_rand(int'($urandom_range(0, 2)));
      run_op(~w, 2);
   endtask

   initial begin
      int mode, ndone;
      load(1'b0, OP_READ, 24'h001000, 8'd16, 32'd0);
      load(1'b1, OP_WRITE, 24'h0abcde, 8'd0, 32'd256);
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_dfifo", 64'(direct_fifo), 64'(1));
      chk("rst_owner", 64'(owner), 64'(1));
      chk("rst_addr", 64'({flash_addr, flash_nbr, flash_nbw}), 64'(0));
      chk("rst_pulses", 64'({flash_read, flash_write, r0_ack, r1_ack, r0_done, r1_done, r0_err, r1_err}), 64'(0));
      rst = 1'b1;

      // Tie from reset: R0 read first, then the R1 multi-frame write.
      prof_fill(1'b1); prof_low(5, 200);
      run_op(1'b0, 1);
      prof_fill(1'b1); prof_low(5, 10); prof_low(35, 300);
      run_op(1'b1, 2);
      do_tie();

      // Start-window boundaries: no fall, fall on the last allowed edge, one edge too late.
      @(negedge clk); load_rand(1'b0); prof_fill(1'b1); run_op(1'b0, 1);
      @(negedge clk); load_rand(1'b1); prof_fill(1'b1); prof_low(256, 8); run_op(1'b1, 1);
      @(negedge clk); load_rand(1'b0); prof_fill(1'b1); prof_low(257, 8); run_op(1'b0, 1);

      for (int i = 0; i < 20; i++) begin
         mode = int'($urandom_range(0, 2));
         if (mode == 2) begin
            do_tie();
         end else begin
            @(negedge clk);
            load_rand(1'(mode));
            prof_rand(int'($urandom_range(0, 2)));
            run_op(1'(mode), 1);
         end
      end

      // CSbar stuck low, then a one-cycle reset.
      @(negedge clk); load_rand(1'b0); prof_fill(1'b1); prof_low(6, MAXK); run_op(1'b0, 1);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_state", 64'({busy, direct_fifo, flash_read, flash_write, r0_done, r1_done}), 64'(6'b010000));
      rst = 1'b1;
      CSbar = 1'b1;
      last_own = 1'b1;
      ndone = 0;
      repeat (80) begin
         @(negedge clk);
         if (r0_done || r1_done) ndone++;
      end
      chk("no_done_after_rst", 64'(ndone), 64'(0));
      do_tie();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench time limit reached");
   end

endmodule
